// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, T-state
// encoding and control-word bit positions.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JC  = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Encoding matches t_state_o directly
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        T6   = 3'd6,
        HALT = 3'd7
    } state_e;

    localparam int unsigned CTRL_W   = 16;
    localparam int unsigned PC_INC   = 0;
    localparam int unsigned PC_OUT   = 1;
    localparam int unsigned PC_LD    = 2;
    localparam int unsigned MAR_LD   = 3;
    localparam int unsigned RAM_OUT  = 4;
    localparam int unsigned IR_LD    = 5;
    localparam int unsigned IR_OUT   = 6;
    localparam int unsigned A_LD     = 7;
    localparam int unsigned A_OUT    = 8;
    localparam int unsigned B_LD     = 9;
    localparam int unsigned ALU_OUT  = 10;
    localparam int unsigned ALU_SUB  = 11;
    localparam int unsigned FLAG_LD  = 12;
    localparam int unsigned OUT_LD   = 13;
    localparam int unsigned HALT_SIG = 14;

    // Instructions whose last active T-state is T4 (everything but LDA/ADD/SUB)
    function automatic logic ends_at_t4(input logic [3:0] op);
        return !(op == OP_LDA || op == OP_ADD || op == OP_SUB);
    endfunction

endpackage

// File: rtl/sap1_step_sync.sv
// Step-button synchronizer with a one-cycle pulse on each synchronized
// rising edge.
module sap1_step_sync
    import sap1_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_i,
    output logic step_pulse_o
);

    // Depths below two are not metastability-safe, so they are raised to two
    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], step_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign step_pulse_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/sap1_ctrl_sequencer.sv
// SAP-1 control sequencer: T-state ring plus combinational microcode decode
// from the registered state, IR opcode and datapath flags.
module sap1_ctrl_sequencer
    import sap1_pkg::*;
#(
    parameter bit          SHORT_CYCLE = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic        step_i,
    input  logic [3:0]  opcode_i,
    input  logic        carry_i,
    input  logic        zero_i,
    output logic [15:0] ctrl_o,
    output logic [2:0]  t_state_o,
    output logic        halted_o
);

    state_e              state_q, state_d;
    logic                step_pulse;
    logic                adv;
    logic [CTRL_W-1:0]   ctrl_w;

    sap1_step_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_step_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_i      (step_i),
        .step_pulse_o(step_pulse)
    );

    assign adv = run_i | step_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (adv) begin
            case (state_q)
                IDLE: state_d = T1;
                T1:   state_d = T2;
                T2:   state_d = T3;
                T3:   state_d = T4;
                T4: begin
                    if (opcode_i == OP_HLT)
                        state_d = HALT;
                    else if (SHORT_CYCLE && ends_at_t4(opcode_i))
                        state_d = T1;
                    else
                        state_d = T5;
                end
                T5:   state_d = (SHORT_CYCLE && opcode_i == OP_LDA) ? T1 : T6;
                T6:   state_d = T1;
                HALT: state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Flags only matter in T4; later changes cannot alter the word
    always_comb begin
        ctrl_w = '0;
        case (state_q)
            T1: begin
                ctrl_w[PC_OUT] = 1'b1;
                ctrl_w[MAR_LD] = 1'b1;
            end
            T2: ctrl_w[PC_INC] = 1'b1;
            T3: begin
                ctrl_w[RAM_OUT] = 1'b1;
                ctrl_w[IR_LD]   = 1'b1;
            end
            T4: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ctrl_w[IR_OUT] = 1'b1;
                        ctrl_w[MAR_LD] = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_w[IR_OUT] = 1'b1;
                        ctrl_w[PC_LD]  = 1'b1;
                    end
                    OP_JC: begin
                        ctrl_w[IR_OUT] = carry_i;
                        ctrl_w[PC_LD]  = carry_i;
                    end
                    OP_JZ: begin
                        ctrl_w[IR_OUT] = zero_i;
                        ctrl_w[PC_LD]  = zero_i;
                    end
                    OP_OUT: begin
                        ctrl_w[A_OUT]  = 1'b1;
                        ctrl_w[OUT_LD] = 1'b1;
                    end
                    OP_HLT: ctrl_w[HALT_SIG] = 1'b1;
                    default: ctrl_w = '0;
                endcase
            end
            T5: begin
                if (opcode_i == OP_LDA) begin
                    ctrl_w[RAM_OUT] = 1'b1;
                    ctrl_w[A_LD]    = 1'b1;
                end else if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    ctrl_w[RAM_OUT] = 1'b1;
                    ctrl_w[B_LD]    = 1'b1;
                end
            end
            T6: begin
                if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    ctrl_w[ALU_OUT] = 1'b1;
                    ctrl_w[A_LD]    = 1'b1;
                    ctrl_w[FLAG_LD] = 1'b1;
                    ctrl_w[ALU_SUB] = (opcode_i == OP_SUB);
                end
            end
            default: ctrl_w = '0;
        endcase
    end

    assign ctrl_o    = ctrl_w;
    assign t_state_o = state_q;
    assign halted_o  = (state_q == HALT);

endmodule
